sample_queue: RTL and testbench



---
 rtl/sample_queue.sv | 109 ++++++++++
 tb/tb_sample_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sample_queue.sv
// sample_queue: dual-channel circular sample buffer that replays the most recent
// TAPS stereo samples oldest-first, framed by the sequencing strobe.
module sample_queue #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned TAPS  = 1021
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    input  logic               wrt_smpl,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               sequencing,
    output logic               full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(TAPS + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BACKOFF  = (AW+1)'(DEPTH - TAPS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TAPS);
    localparam logic [CW-1:0] IDX_LAST = CW'(TAPS - 1);

    if (DEPTH < TAPS + 2) begin : g_bad_params
        $error("sample_queue: DEPTH must be at least TAPS+2");
    end

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wptr, rptr, rptr_start;
    logic [AW:0]   back_sum, back_wrap;
    logic [CW-1:0] cnt, idx;
    logic          trigger, rd_en;

    logic signed [15:0] mem_l [DEPTH];
    logic signed [15:0] mem_r [DEPTH];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign full    = (cnt == CNT_MAX);
    assign trigger = wrt_smpl && (cnt >= IDX_LAST) && (state == IDLE);

    // Oldest window sample is (wptr + 1 - TAPS) mod DEPTH; add DEPTH-TAPS+1 to stay non-negative.
    always_comb begin
        back_sum  = {1'b0, wptr} + BACKOFF;
        back_wrap = (back_sum >= DEPTH_X) ? back_sum - DEPTH_X : back_sum;
        rptr_start = back_wrap[AW-1:0];
    end

    always_comb begin
        state_nxt  = state;
        sequencing = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) state_nxt = READ;
            end
            READ: begin
                sequencing = 1'b1;
                rd_en      = 1'b1;
                if (idx == IDX_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                sequencing = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            idx      <= '0;
            lft_out  <= '0;
            rght_out <= '0;
        end else begin
            state <= state_nxt;
            if (wrt_smpl) begin
                wptr <= ptr_inc(wptr);
                if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            end
            if (trigger) begin
                rptr <= rptr_start;
                idx  <= '0;
            end else if (rd_en) begin
                rptr     <= ptr_inc(rptr);
                idx      <= idx + CW'(1);
                lft_out  <= mem_l[rptr];
                rght_out <= mem_r[rptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrt_smpl) begin
            mem_l[wptr] <= lft_smpl;
            mem_r[wptr] <= rght_smpl;
        end
    end

endmodule

// File: tb/tb_sample_queue.sv
// Scoreboard bench for sample_queue: small instance (DEPTH=8, TAPS=5) plus a default-parameter instance.
module tb_sample_queue;
    localparam int TAPS = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               s_wrt;
    logic signed [15:0] s_lft, s_rght, s_lft_out, s_rght_out;
    logic               s_seq, s_full;

    logic               d_wrt;
    logic signed [15:0] d_lft, d_rght, d_lft_out, d_rght_out;
    logic               d_seq, d_full;

    sample_queue #(.DEPTH(8), .TAPS(TAPS)) u_small (
        .clk(clk), .rst_n(rst_n),
        .lft_smpl(s_lft), .rght_smpl(s_rght), .wrt_smpl(s_wrt),
        .lft_out(s_lft_out), .rght_out(s_rght_out),
        .sequencing(s_seq), .full(s_full)
    );

    sample_queue u_dflt (
        .clk(clk), .rst_n(rst_n),
        .lft_smpl(d_lft), .rght_smpl(d_rght), .wrt_smpl(d_wrt),
        .lft_out(d_lft_out), .rght_out(d_rght_out),
        .sequencing(d_seq), .full(d_full)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state, owned by the monitor process.
    logic signed [15:0] sb_q[$];
    logic signed [15:0] hist[$];
    int                 m_cnt  = 0;
    int                 m_left = 0;
    logic signed [15:0] m_lout = '0;
    logic signed [15:0] m_rout = '0;

    initial begin : monitor
        logic signed [15:0] e;
        bit running;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                sb_q.delete();
                hist.delete();
                m_cnt  = 0;
                m_left = 0;
                m_lout = '0;
                m_rout = '0;
                continue;
            end
            check("seq", s_seq, (m_left != 0));
            check("full", s_full, (m_cnt == TAPS));
            if (m_left != 0 && m_left != TAPS + 1) begin
                check("sb_avail", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    m_lout = e;
                    m_rout = -e;
                end
            end
            check("lft_out", s_lft_out, m_lout);
            check("rght_out", s_rght_out, m_rout);
            running = (m_left != 0);
            if (m_left != 0) m_left--;
            if (s_wrt) begin
                hist.push_back(s_lft);
                if (hist.size() > TAPS) void'(hist.pop_front());
                if (m_cnt < TAPS) m_cnt++;
                if (m_cnt == TAPS && !running) begin
                    foreach (hist[i]) sb_q.push_back(hist[i]);
                    m_left = TAPS + 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int v);
        s_wrt  = 1'b1;
        s_lft  = 16'(v);
        s_rght = 16'(-v);
        @(posedge clk);
        #1;
        s_wrt = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int width;
        logic signed [15:0] last_l;
        rst_n = 1'b0;
        s_wrt = 1'b0; s_lft = '0; s_rght = '0;
        d_wrt = 1'b0; d_lft = '0; d_rght = '0;
        idle(3);
        check("rst_seq", s_seq, 0);
        check("rst_full", s_full, 0);
        check("rst_lft", s_lft_out, 0);
        check("rst_rght", s_rght_out, 0);
        rst_n = 1'b1;
        idle(2);

        // Fill, steady state across pointer wrap.
        for (int v = 1; v <= 20; v++) begin
            wr(v);
            if (v < 20) idle(9);
        end
        // Write 21 lands in the third sequencing cycle of the 16..20 replay.
        idle(2);
        wr(21);
        idle(10);
        wr(22);
        idle(10);

        // Reset during READ.
        wr(23);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_seq", s_seq, 0);
        check("midrst_full", s_full, 0);
        check("midrst_lft", s_lft_out, 0);
        check("midrst_rght", s_rght_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        for (int v = 30; v <= 34; v++) begin
            wr(v);
            idle(9);
        end
        idle(5);
        check("sb_drained", sb_q.size(), 0);

        // Default parameters: back-to-back ramp fill.
        for (int i = 0; i < 1021; i++) begin
            d_wrt  = 1'b1;
            d_lft  = 16'(100 + i);
            d_rght = 16'(-(100 + i));
            @(posedge clk);
            #1;
        end
        d_wrt = 1'b0;
        @(negedge clk);
        check("dflt_full", d_full, 1);
        width  = 0;
        last_l = '0;
        while (d_seq === 1'b1 && width < 2000) begin
            width++;
            if (width == 2) begin
                check("dflt_first_l", d_lft_out, 100);
                check("dflt_first_r", d_rght_out, -100);
            end
            last_l = d_lft_out;
            @(negedge clk);
        end
        check("dflt_width", width, 1022);
        check("dflt_last_l", last_l, 1120);
        idle(3);
        check("dflt_seq_low", d_seq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
